fifo_rd_adapter: RTL

Read-side adapter for the team's synchronous `fifo` block. It drains a FIFO that has one-cycle read latency and presents the words on a valid/ready stream. Words go to a downstream consumer such as `controller`. A small internal buffer absorbs in-flight reads, so the stream runs at full throughput with no combinational path from out_ready to fifo_rd_en.

---
 rtl/fifo_rd_pkg.sv | 18 +
 rtl/fifo_rd_buf.sv | 70 +++++++
 rtl/fifo_rd_adapter.sv | 83 ++++++++
 3 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared widths and pointer helpers for the FIFO read-side adapter.
// Counts and pointers use CNT_W bits, which covers buffer depths up to MAX_BUF_DEPTH.
package fifo_rd_pkg;

  localparam int unsigned MAX_BUF_DEPTH = 127;
  localparam int unsigned CNT_W         = $clog2(MAX_BUF_DEPTH + 1) + 1;
  localparam int unsigned STAT_W        = 16;

  // The explicit compare lets the wrap work for depths that are not a power of two.
  function automatic logic [CNT_W-1:0] ptr_inc(input logic [CNT_W-1:0] ptr,
                                               input logic [CNT_W-1:0] depth);
    if (ptr == depth - CNT_W'(1)) begin
      return '0;
    end
    return ptr + CNT_W'(1);
  endfunction

endpackage

// File: rtl/fifo_rd_buf.sv
// Circular holding buffer for the read adapter: storage, pointers, occupancy count.
// The head word is kept in a register so it holds its last value when the buffer drains.
module fifo_rd_buf
  import fifo_rd_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned BUF_DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [CNT_W-1:0] count_o,
  output logic [WIDTH-1:0] rd_data_o
);

  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(BUF_DEPTH);

  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;

  // The head only reloads when the buffer will be non-empty; a write landing on the new head slot is forwarded.
  always_comb begin
    wr_ptr_d = wr_en_i ? ptr_inc(wr_ptr_q, DEPTH) : wr_ptr_q;
    rd_ptr_d = rd_en_i ? ptr_inc(rd_ptr_q, DEPTH) : rd_ptr_q;
    count_d  = count_q + CNT_W'(wr_en_i) - CNT_W'(rd_en_i);
    head_d   = head_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    if (count_d != '0) begin
      if (wr_en_i && (wr_ptr_q == rd_ptr_d)) begin
        head_d = wr_data_i;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign count_o   = count_q;
  assign rd_data_o = head_q;

endmodule

// File: rtl/fifo_rd_adapter.sv
// Drains a one-cycle-latency FIFO onto a valid/ready stream at full throughput.
// Define FIFO_RD_ADAPTER_STATS_EN to enable the saturating accepted-word counter.
module fifo_rd_adapter
  import fifo_rd_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned BUF_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [WIDTH-1:0]  fifo_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [STAT_W-1:0] word_count
);

  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(BUF_DEPTH);

  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] count;
  logic             capture;
  logic             pop;

  // Reserving space for the in-flight word keeps out_ready out of the read-issue path.
  always_comb begin
    fifo_rd_en = !fifo_empty && !flush && !rst && ((count + CNT_W'(inflight_q)) < DEPTH);
    inflight_d = fifo_rd_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  assign capture   = inflight_q && !flush;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;

  fifo_rd_buf #(
    .WIDTH    (WIDTH),
    .BUF_DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (flush),
    .wr_en_i  (capture),
    .wr_data_i(fifo_rd_data),
    .rd_en_i  (pop),
    .count_o  (count),
    .rd_data_o(out_data)
  );

`ifdef FIFO_RD_ADAPTER_STATS_EN
  logic [STAT_W-1:0] word_count_q, word_count_d;

  always_comb begin
    word_count_d = word_count_q;
    if (pop && (word_count_q != '1)) begin
      word_count_d = word_count_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_count_q <= '0;
    end else begin
      word_count_q <= word_count_d;
    end
  end

  assign word_count = word_count_q;
`else
  assign word_count = '0;
`endif

endmodule
